// File: rtl/act_sched_pkg.sv
// ---------------------------------------------------------------------------
// act_sched_pkg
// Shared definitions for the activation-unit scheduler: function codes that
// select one of the four shared activation units, the scheduler FSM state
// encoding, and a helper that turns a function code into a unit enable.
// ---------------------------------------------------------------------------
package act_sched_pkg;

   localparam int NUM_FUNC = 4;

   localparam logic [1:0] FN_RELU     = 2'd0;
   localparam logic [1:0] FN_HARDTANH = 2'd1;
   localparam logic [1:0] FN_SIGMOID  = 2'd2;
   localparam logic [1:0] FN_LEAKY    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // One-hot unit enable for a function code; bit position equals the code.
   function automatic logic [NUM_FUNC-1:0] func_onehot(input logic [1:0] func);
      return NUM_FUNC'(1) << func;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// starting at the pointer lane and wrapping around, and reports the first
// requesting lane.
//
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   ID_W     lane with highest priority this cycle
//   grant     out  NUM_REQ  one-hot grant, zero when nothing requests
//   grant_id  out  ID_W     encoded index of the granted lane
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   int   idx;
   logic found;

   // Walk the lanes in priority order (ptr, ptr+1, ... wrapping) and keep
   // only the first hit so the grant can never be multi-hot.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/act_unit_scheduler.sv
// ---------------------------------------------------------------------------
// act_unit_scheduler
// Shares one bank of four activation units (relu, hardtanh, sigmoid,
// leakyRelu) among NUM_REQ requester lanes. One request is in flight at a
// time: a lane is granted round-robin, its operand is driven to the unit
// selected by its function code, the unit result (or a timeout error) is
// returned on a valid/ready response port.
//
// Ports:
//   iClk, iRst          clock (rising edge), async active-low reset
//   req_valid/ready     per-lane request handshake, ready is one-hot or zero
//   req_data/req_func   per-lane packed operand and function code
//   unit_data/unit_en   shared operand bus and per-unit enables
//   unit_out/unit_rdy   per-unit packed results and ready flags
//   resp_valid/ready    response handshake
//   resp_data/id/func   result, originating lane, function applied
//   resp_err            timeout flag, qualified by resp_valid
//   busy                high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module act_unit_scheduler
   import act_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ*2-1:0]     req_func,
   output logic [WIDTH-1:0]         unit_data,
   output logic [NUM_FUNC-1:0]      unit_en,
   input  logic [NUM_FUNC*WIDTH-1:0] unit_out,
   input  logic [NUM_FUNC-1:0]      unit_rdy,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic [ID_W-1:0]          resp_id,
   output logic [1:0]               resp_func,
   output logic                     resp_err,
   output logic                     busy
);

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [7:0]        wait_cnt;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]   grant_id;
   logic [WIDTH-1:0]  grant_data;
   logic [1:0]        grant_func;
   logic              sel_rdy;
   logic [WIDTH-1:0]  sel_out;
   logic [ID_W-1:0]   next_ptr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Operand/function of the lane the arbiter picked, and the result/ready
   // of the unit the in-flight request targets. resp_func doubles as the
   // latched function code, so rdy from any other unit is never looked at.
   always_comb begin
      grant_data = req_data[int'(grant_id)*WIDTH +: WIDTH];
      grant_func = req_func[int'(grant_id)*2 +: 2];
      sel_rdy    = unit_rdy[resp_func];
      sel_out    = unit_out[int'(resp_func)*WIDTH +: WIDTH];
      next_ptr   = (resp_id == ID_W'(NUM_REQ-1)) ? '0 : resp_id + ID_W'(1);
   end

   // The accept strobe is only offered while idle. It is also held low
   // during reset so that every output reads zero while iRst is asserted,
   // even if lanes are already requesting.
   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && iRst) begin
         req_ready = grant;
      end
      busy = (state != ST_IDLE);
   end

   // Scheduler FSM. The enable and operand are registered on the accept
   // edge so they are already valid in the ISSUE cycle, and they stay up
   // through WAIT and RESP until the response is taken. The WAIT counter
   // runs 0..TIMEOUT-1, giving exactly TIMEOUT WAIT cycles; rdy is tested
   // before the timeout so a rdy on the last cycle still wins.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         wait_cnt   <= '0;
         unit_data  <= '0;
         unit_en    <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         resp_func  <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  unit_data <= grant_data;
                  unit_en   <= func_onehot(grant_func);
                  resp_func <= grant_func;
                  resp_id   <= grant_id;
                  resp_data <= '0;
                  resp_err  <= 1'b0;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (sel_rdy) begin
                  resp_data  <= sel_out;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else if (wait_cnt == 8'(TIMEOUT-1)) begin
                  resp_data  <= '0;
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  unit_en    <= '0;
                  rr_ptr     <= next_ptr;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/act_unit_scheduler.md
Name: act_unit_scheduler

Overview:
- Time-multiplexes one bank of four activation units (relu, hardtanh, sigmoid, leakyRelu) among NUM_REQ requester lanes.
- Arbitrates requests round-robin and issues each accepted operand to the selected unit via its enable/rdy pair.
- Returns the result with requester id and function code over a valid/ready response port.
- Sits between the layer datapath and the shared activation units; replaces the per-lane unit instances and their hard-wired enables.

Parameters:
NUM_REQ, 4, number of requester lanes (2..8)
WIDTH, 16, fixed-point operand/result width
ID_W, 2, requester id width, equals clog2(NUM_REQ)
TIMEOUT, 15, max WAIT cycles for unit rdy before abort (1..255)

Ports:
iClk  in  1  clock, rising edge
iRst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-lane request valid
req_ready  out  NUM_REQ  per-lane accept, one-hot or zero
req_data  in  NUM_REQ*WIDTH  per-lane operand, lane i at [(i+1)*WIDTH-1:i*WIDTH]
req_func  in  NUM_REQ*2  per-lane function code, lane i at [2i+1:2i]
unit_data  out  WIDTH  shared operand bus to all four units
unit_en  out  4  unit enables, bit = function code
unit_out  in  4*WIDTH  unit dataOut, unit f at [(f+1)*WIDTH-1:f*WIDTH]
unit_rdy  in  4  unit rdy flags
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_data  out  WIDTH  activation result
resp_id  out  ID_W  originating lane
resp_func  out  2  function applied
resp_err  out  1  timeout flag, qualified by resp_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Function codes: 0 relu, 1 hardtanh, 2 sigmoid, 3 leakyRelu.
- Reset (iRst low, async): state IDLE, rr pointer 0, all outputs 0, WAIT counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first valid lane at or after the rr pointer (wrapping), and assert req_ready[grant] combinationally in that cycle.
  - On the clock edge, latch operand, func and id, then go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE (1 cycle): unit_data = latched operand; unit_en[func] = 1, other enables 0; counter cleared; go to WAIT.
- WAIT:
  - unit_data held; unit_en held high for the selected unit; counter increments.
  - unit_rdy[func] high: capture unit_out[func] into resp_data, resp_err = 0, go to RESP.
  - rdy of non-selected units is ignored.
  - Counter reaches TIMEOUT without rdy: resp_data = 0, resp_err = 1, go to RESP.
  - rdy and timeout in the same cycle: rdy wins, no error.
- RESP:
  - resp_valid = 1; resp_data, resp_id, resp_func and resp_err are stable until resp_valid && resp_ready.
  - On handshake: rr pointer = (id+1) mod NUM_REQ, unit_en cleared, go to IDLE.
- Latency: accept at cycle T; unit_en rises at T+1; rdy sampled from T+2; rdy at cycle k gives resp_valid at k+1. Minimum accept-to-resp_valid is 3 cycles.
- Throughput: at most one request in flight. Back-to-back requests are spaced at least 4 cycles apart (IDLE, ISSUE, WAIT, RESP).
- Fairness: a continuously valid lane waits at most NUM_REQ-1 grants.
- Reset mid-operation: in-flight request is dropped with no response; the requester must re-issue.
- req_data/req_func are sampled only in the accept cycle and may change afterwards.

Decomposition:
- Package act_sched_pkg holds:
  - function-code localparams FN_RELU=2'd0, FN_HARDTANH=2'd1, FN_SIGMOID=2'd2, FN_LEAKY=2'd3
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP
  - NUM_FUNC=4
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and pointer; outputs one-hot grant and encoded id. Purely combinational.

Test Plan:
- Lane 2 req_data=16'h2000 (0.5, 14 frac bits), func=2, unit_rdy[2] two cycles after enable, unit_out[2]=16'h2760 -> req_ready[2] pulse, unit_en=4'b0100, resp_valid with data 16'h2760, id 2, func 2, err 0.
- All four lanes valid continuously, pointer 0 -> grant order 0,1,2,3,0; no lane starved; req_ready never multi-hot.
- func=1, unit_rdy held low -> resp_valid after TIMEOUT=15 WAIT cycles with data 0, resp_err 1; next grant proceeds normally.
- resp_ready held low 10 cycles in RESP -> resp fields stable; no req_ready asserted; the new grant follows the handshake.
- iRst driven low during WAIT -> all outputs 0 immediately; after release, lane 0 granted first and the old request gets no response.
- unit_rdy[0] pulses while func=3 is pending, then unit_rdy[3] with 16'hFFF0 -> the stray rdy is ignored; resp_data 16'hFFF0.
